// File: rtl/full_bridge_pattern.sv
// Full-bridge gate pattern generator: IDLE/POS/NEG/FAULT with minimum dwell,
// latched fault shutdown and a wrapping commutation counter.
module full_bridge_pattern #(
    parameter int MIN_ON    = 50,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_sigma,
    input  logic                 i_fault,
    input  logic                 i_fault_clear,
    output logic [3:0]           o_gate,
    output logic [1:0]           o_state,
    output logic                 o_fault,
    output logic [CNT_WIDTH-1:0] o_switch_count
);

    localparam int DWELL = (MIN_ON > 1) ? MIN_ON - 1 : 0;
    localparam int DW    = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [DW-1:0] DWELL_LD = DW'(DWELL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_POS   = 2'b01,
        ST_NEG   = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [3:0]           gate_q, gate_d;
    logic                 fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dwell_d = (dwell_q != '0) ? dwell_q - DW'(1) : dwell_q;
        if (i_fault) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_FAULT: begin
                    if (i_fault_clear) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (i_enable) begin
                        state_d = i_sigma ? ST_POS : ST_NEG;
                        dwell_d = DWELL_LD;
                    end
                end
                ST_POS: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                    end else if (dwell_q == '0 && !i_sigma) begin
                        state_d = ST_NEG;
                        dwell_d = DWELL_LD;
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
                ST_NEG: begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                    end else if (dwell_q == '0 && i_sigma) begin
                        state_d = ST_POS;
                        dwell_d = DWELL_LD;
                        count_d = count_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Gate and fault flags are registered from the next state so they
    // change on the same edge as o_state.
    always_comb begin
        gate_d  = 4'b0000;
        fault_d = (state_d == ST_FAULT);
        case (state_d)
            ST_POS:  gate_d = 4'b1001;
            ST_NEG:  gate_d = 4'b0110;
            default: gate_d = 4'b0000;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            count_q <= '0;
            gate_q  <= 4'b0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            count_q <= count_d;
            gate_q  <= gate_d;
            fault_q <= fault_d;
        end
    end

    assign o_gate         = gate_q;
    assign o_state        = state_q;
    assign o_fault        = fault_q;
    assign o_switch_count = count_q;

endmodule

// File: tb/tb_full_bridge_pattern.sv
// Bench for full_bridge_pattern: vector table, directed corner sequences and
// random stimulus against a residence-time reference model.
module tb_full_bridge_pattern;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, sig = 1'b0, flt = 1'b0, clr = 1'b0;

    logic [3:0]  g0, g1;
    logic [1:0]  s0, s1;
    logic        f0, f1;
    logic [15:0] c0;
    logic [3:0]  c1;

    full_bridge_pattern #(.MIN_ON(50), .CNT_WIDTH(16)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_sigma(sig),
        .i_fault(flt), .i_fault_clear(clr),
        .o_gate(g0), .o_state(s0), .o_fault(f0), .o_switch_count(c0)
    );

    full_bridge_pattern #(.MIN_ON(0), .CNT_WIDTH(4)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_sigma(sig),
        .i_fault(flt), .i_fault_clear(clr),
        .o_gate(g1), .o_state(s1), .o_fault(f1), .o_switch_count(c1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int illegal = 0;

    typedef struct {
        int st;
        int res;
        int cnt;
    } mdl_t;

    mdl_t m0 = '{0, 0, 0};
    mdl_t m1 = '{0, 0, 0};

    // st: 0 idle, 1 pos, 2 neg, 3 fault; res = cycles since entering pos/neg
    function automatic mdl_t upd(mdl_t m, int min_on, int modv,
                                 logic r_, logic e_, logic s_,
                                 logic f_, logic c_);
        mdl_t r = m;
        int need = (min_on < 1) ? 1 : min_on;
        int want = s_ ? 1 : 2;
        if (r_) begin
            r.st = 0; r.res = 0; r.cnt = 0;
        end else if (f_) begin
            r.st = 3;
        end else if (m.st == 3) begin
            if (c_) r.st = 0;
        end else if (!e_) begin
            r.st = 0;
        end else if (m.st == 0) begin
            r.st = want; r.res = 0;
        end else begin
            r.res = m.res + 1;
            if (r.res >= need && want != m.st) begin
                r.st = want; r.res = 0; r.cnt = (m.cnt + 1) % modv;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] pk(int st, int cnt);
        logic [1:0]  s = 2'(st);
        logic [3:0]  g = (st == 1) ? 4'b1001 : (st == 2) ? 4'b0110 : 4'b0000;
        logic        f = (st == 3);
        logic [15:0] c = 16'(cnt);
        return {9'b0, s, g, f, c};
    endfunction

    function automatic logic [31:0] o0();
        return {9'b0, s0, g0, f0, c0};
    endfunction

    function automatic logic [31:0] o1();
        return {9'b0, s1, g1, f1, 12'b0, c1};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m0 = upd(m0, 50, 65536, rst, en, sig, flt, clr);
        m1 = upd(m1, 0, 16, rst, en, sig, flt, clr);
        #1;
        if (!(g0 inside {4'b0000, 4'b1001, 4'b0110})) illegal++;
        if (!(g1 inside {4'b0000, 4'b1001, 4'b0110})) illegal++;
        chk("dut0_model", o0(), pk(m0.st, m0.cnt));
        chk("dut1_model", o1(), pk(m1.st, m1.cnt));
    endtask

    task automatic drive(logic r_, logic e_, logic s_, logic f_, logic c_);
        rst = r_; en = e_; sig = s_; flt = f_; clr = c_;
    endtask

    typedef struct {
        logic r, e, s, f, c;
        int   st;
        int   cnt;
    } vec_t;

    vec_t tbl[13];
    logic [15:0] base;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].f, tbl[i].c);
            step();
            chk($sformatf("vec%0d", i), o0(), pk(tbl[i].st, tbl[i].cnt));
        end

        // Dwell: request from entry+5 commutes only at entry+50
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0); step();
        chk("entry_pos", o0(), pk(1, 0));
        for (int i = 1; i < 50; i++) begin
            sig = (i < 5);
            step();
        end
        chk("dwell_hold", o0(), pk(1, 0));
        step();
        chk("dwell_commute", o0(), pk(2, 1));

        // Short pulse inside the dwell window is dropped
        for (int i = 51; i <= 160; i++) begin
            sig = (i >= 61 && i <= 63);
            step();
        end
        chk("pulse_lost", o0(), pk(2, 1));

        // Square wave, 20 periods of 200 cycles, starting from POS
        sig = 1'b1;
        repeat (60) step();
        chk("pos_before_sq", o0(), pk(1, 2));
        base = c0;
        for (int p = 0; p < 20; p++) begin
            sig = 1'b0; repeat (100) step();
            sig = 1'b1; repeat (100) step();
        end
        chk("sq_count", 32'(c0 - base), 32'd40);

        // Fault mid-dwell in NEG, clear blocked while fault still high
        sig = 1'b0; step();
        repeat (10) step();
        chk("neg_mid", o0(), pk(2, 43));
        flt = 1'b1; step();
        chk("fault_entry", o0(), pk(3, 43));
        flt = 1'b0; step();
        chk("fault_hold", o0(), pk(3, 43));
        flt = 1'b1; clr = 1'b1; step();
        chk("fault_clr_blocked", o0(), pk(3, 43));
        flt = 1'b0; step();
        chk("fault_exit", o0(), pk(0, 43));
        clr = 1'b0; sig = 1'b1; step();
        chk("reenter", o0(), pk(1, 43));

        // Enable drop mid-dwell and on a commutation edge
        repeat (10) step();
        en = 1'b0; step();
        chk("en_drop_dwell", o0(), pk(0, 43));
        en = 1'b1; sig = 1'b1; step();
        repeat (60) step();
        en = 1'b0; sig = 1'b0; step();
        chk("en_drop_commute", o0(), pk(0, 43));

        // Seven commutations ending in NEG, then reset
        drive(1, 0, 0, 0, 0); step();
        drive(0, 1, 1, 0, 0); step();
        for (int k = 0; k < 7; k++) begin
            sig = ~sig;
            repeat (60) step();
        end
        chk("cnt7_neg", o0(), pk(2, 7));
        rst = 1'b1; step();
        chk("reset_mid0", o0(), pk(0, 0));
        chk("reset_mid1", o1(), pk(0, 0));

        // MIN_ON=0, 4-bit counter: one-cycle dwell and wrap 15 -> 0
        drive(0, 1, 1, 0, 0); step();
        chk("min_on0_entry", o1(), pk(1, 0));
        sig = 1'b0; step();
        chk("min_on0_fast", o1(), pk(2, 1));
        for (int k = 2; k <= 15; k++) begin
            sig = ~sig;
            step();
        end
        chk("wrap15", o1(), pk(2, 15));
        sig = ~sig; step();
        chk("wrap0", o1(), pk(1, 0));

        // Random traffic against the reference model
        drive(1, 0, 0, 0, 0); step();
        rst = 1'b0;
        repeat (3000) begin
            rst = ($urandom % 256) == 0;
            en  = ($urandom % 32) != 0;
            flt = ($urandom % 80) == 0;
            clr = ($urandom % 6) == 0;
            if (($urandom % 40) == 0) sig = ~sig;
            step();
        end

        chk("illegal_gate", 32'(illegal), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
